sensor_input_conditioner: RTL and testbench

//  Front-end stage feeding the irrigation top level. Synchronises, debounces and

---
 rtl/sensor_input_conditioner_pkg.sv | 30 +++
 rtl/sensor_input_conditioner_if.sv | 34 +++
 rtl/sensor_input_conditioner_debounce_channel.sv | 59 +++++
 rtl/sensor_input_conditioner.sv | 113 +++++++++++
 tb/tb_sensor_input_conditioner.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sensor_input_conditioner_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : irrigation_pkg
//  Purpose  : Shared channel indices, counts and default timing for the
//             irrigation front-end input conditioner.
//  Revision : 1.0 - initial release
// ============================================================================
package irrigation_pkg;

    // Sensor bit positions on raw_sensors / stable_sensors
    localparam int SNS_LOW_WATER  = 0;
    localparam int SNS_MID_WATER  = 1;
    localparam int SNS_HIGH_WATER = 2;
    localparam int SNS_EARTH_HUM  = 3;
    localparam int SNS_AIR_HUM    = 4;
    localparam int SNS_LOW_TEMP   = 5;

    // Button bit positions on raw_buttons / button_pulse
    localparam int BTN_PULSE_3    = 0;
    localparam int BTN_PULSE_2    = 1;

    localparam int N_SENSORS      = 6;
    localparam int N_BUTTONS      = 2;

    // Default debounce timing
    localparam int DEFAULT_TICK_DIV        = 16;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

endpackage : irrigation_pkg
`default_nettype wire

// File: rtl/sensor_input_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Module   : sensor_input_conditioner_if
//  Purpose  : Field-input bundle between the raw I/O side and the input
//             conditioner. master = field/raw side, slave = conditioner.
//  Revision : 1.0 - initial release
// ============================================================================
interface sensor_input_conditioner_if;
    import irrigation_pkg::*;

    logic [N_SENSORS-1:0] raw_sensors;
    logic [N_BUTTONS-1:0] raw_buttons;
    logic [N_SENSORS-1:0] stable_sensors;
    logic [N_BUTTONS-1:0] button_pulse;
    logic                 sensors_valid;

    modport master (
        output raw_sensors,
        output raw_buttons,
        input  stable_sensors,
        input  button_pulse,
        input  sensors_valid
    );

    modport slave (
        input  raw_sensors,
        input  raw_buttons,
        output stable_sensors,
        output button_pulse,
        output sensors_valid
    );

endinterface : sensor_input_conditioner_if
`default_nettype wire

// File: rtl/sensor_input_conditioner_debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_channel
//  Purpose  : One input channel: two-flop synchroniser, optional polarity
//             inversion, tick-counted debounce and the accepted-level flop.
//  Revision : 1.0 - initial release
// ============================================================================
module debounce_channel #(
    parameter logic RESET_VALUE     = 1'b0,  // synchroniser idle level
    parameter logic INVERT          = 1'b0,  // 1 for active-low inputs
    parameter int   DEBOUNCE_CYCLES = 4
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic tick,
    input  wire logic raw,
    output logic      stable
);

    localparam int                c_cnt_w = $clog2(DEBOUNCE_CYCLES + 1);
    // Reaching this count on a tick means the DEBOUNCE_CYCLES-th differing tick
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_sync_meta;
    logic               r_sync;
    logic               r_stable;
    logic [c_cnt_w-1:0] r_count;
    logic               w_level;

    // Active-high view of the synchronised input
    assign w_level = r_sync ^ INVERT;

    // Synchronise, then accept a new level after enough consecutive differing ticks
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync_meta <= RESET_VALUE;
            r_sync      <= RESET_VALUE;
            r_stable    <= 1'b0;
            r_count     <= '0;
        end else begin
            r_sync_meta <= raw;
            r_sync      <= r_sync_meta;
            if (w_level == r_stable) begin
                r_count <= '0;
            end else if (tick) begin
                if (r_count == c_last) begin
                    r_stable <= w_level;
                    r_count  <= '0;
                end else begin
                    r_count  <= r_count + 1'b1;
                end
            end
        end
    end

    assign stable = r_stable;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/sensor_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : sensor_input_conditioner
//  Purpose  : Synchronises and debounces the six level sensors and the two
//             active-low buttons; turns accepted presses into 1-clock pulses
//             and flags when the first debounce window has elapsed.
//  Revision : 1.0 - initial release
// ============================================================================
module sensor_input_conditioner
    import irrigation_pkg::*;
#(
    parameter int TICK_DIV        = DEFAULT_TICK_DIV,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  wire logic                 clock,
    input  wire logic                 reset,
    sensor_input_conditioner_if.slave sig
);

    localparam int                    c_pre_w    = $clog2(TICK_DIV);
    localparam logic [c_pre_w-1:0]    c_pre_last = c_pre_w'(TICK_DIV - 1);
    localparam int                    c_start_w  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_start_w-1:0]  c_start_last = c_start_w'(DEBOUNCE_CYCLES - 1);

    logic [c_pre_w-1:0]   r_prescale;
    logic [c_start_w-1:0] r_startup;
    logic                 r_valid;
    logic                 r_valid_d;
    logic [N_BUTTONS-1:0] r_buttons_prev;
    logic [N_BUTTONS-1:0] r_pulse;
    logic                 w_tick;
    logic [N_SENSORS-1:0] w_stable_sensors;
    logic [N_BUTTONS-1:0] w_stable_buttons;

    assign w_tick = (r_prescale == c_pre_last);

    // Free-running sample-tick prescaler shared by every channel
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prescale <= '0;
        end else if (w_tick) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + 1'b1;
        end
    end

    // Count startup ticks; valid rises on the edge of the last window tick and sticks
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_startup <= '0;
            r_valid   <= 1'b0;
        end else if (w_tick && !r_valid) begin
            if (r_startup == c_start_last) begin
                r_valid <= 1'b1;
            end else begin
                r_startup <= r_startup + 1'b1;
            end
        end
    end

    generate
        for (genvar i = 0; i < N_SENSORS; i++) begin : g_sensor
            debounce_channel #(
                .RESET_VALUE     (1'b0),
                .INVERT          (1'b0),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_chan (
                .clock  (clock),
                .reset  (reset),
                .tick   (w_tick),
                .raw    (sig.raw_sensors[i]),
                .stable (w_stable_sensors[i])
            );
        end

        // Buttons idle high (released) and are inverted so 1 = pressed
        for (genvar i = 0; i < N_BUTTONS; i++) begin : g_button
            debounce_channel #(
                .RESET_VALUE     (1'b1),
                .INVERT          (1'b1),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_chan (
                .clock  (clock),
                .reset  (reset),
                .tick   (w_tick),
                .raw    (sig.raw_buttons[i]),
                .stable (w_stable_buttons[i])
            );
        end
    endgenerate

    // Rising-edge pulse, qualified by valid as it stood before the press was
    // accepted, so a press accepted on the same edge as valid (held through
    // reset) is suppressed
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_buttons_prev <= '0;
            r_valid_d      <= 1'b0;
            r_pulse        <= '0;
        end else begin
            r_buttons_prev <= w_stable_buttons;
            r_valid_d      <= r_valid;
            r_pulse        <= w_stable_buttons & ~r_buttons_prev & {N_BUTTONS{r_valid_d}};
        end
    end

    assign sig.stable_sensors = w_stable_sensors;
    assign sig.button_pulse   = r_pulse;
    assign sig.sensors_valid  = r_valid;

endmodule : sensor_input_conditioner
`default_nettype wire

// File: tb/tb_sensor_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sensor_input_conditioner
//  Purpose  : Directed stimulus with a cycle-level behavioural model of the
//             conditioner, compared every clock, plus literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sensor_input_conditioner;
    import irrigation_pkg::*;

    localparam int TD = 4;
    localparam int DC = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sensor_input_conditioner_if sig ();

    sensor_input_conditioner #(
        .TICK_DIV        (TD),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .sig   (sig)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Channels 0..5 = sensors, 6..7 = buttons (pressed level = 1)
    logic [7:0] m_d1, m_d2, m_stable;
    int         m_cnt [8];
    int         m_ticks, m_cyc;
    logic       m_valid;
    logic [1:0] m_pend, m_pulse;

    task automatic model_reset();
        m_d1 = 8'hC0;
        m_d2 = 8'hC0;
        m_stable = 8'h00;
        for (int c = 0; c < 8; c++) m_cnt[c] = 0;
        m_ticks = 0;
        m_cyc = 0;
        m_valid = 1'b0;
        m_pend = 2'b00;
        m_pulse = 2'b00;
    endtask

    task automatic model_step();
        logic       tick, old_valid, lvl;
        logic [7:0] old_stable;
        tick = ((m_cyc % TD) == TD - 1);
        old_valid = m_valid;
        old_stable = m_stable;
        for (int c = 0; c < 8; c++) begin
            lvl = (c < 6) ? m_d2[c] : ~m_d2[c];
            if (lvl == m_stable[c]) begin
                m_cnt[c] = 0;
            end else if (tick) begin
                m_cnt[c] = m_cnt[c] + 1;
                if (m_cnt[c] == DC) begin
                    m_stable[c] = lvl;
                    m_cnt[c] = 0;
                end
            end
        end
        if (tick && m_ticks < DC) m_ticks = m_ticks + 1;
        m_valid = (m_ticks >= DC);
        m_pulse = m_pend;
        for (int b = 0; b < 2; b++)
            m_pend[b] = m_stable[6+b] & ~old_stable[6+b] & old_valid;
        m_d2 = m_d1;
        m_d1 = {sig.raw_buttons, sig.raw_sensors};
        m_cyc = m_cyc + 1;
    endtask

    // Advance the model on every edge and compare all outputs shortly after
    initial begin
        forever begin
            @(posedge clock);
            if (reset) model_reset();
            else model_step();
            #1;
            check("cmp_stable_sensors", {2'b00, sig.stable_sensors}, {2'b00, m_stable[5:0]});
            check("cmp_button_pulse", {6'b0, sig.button_pulse}, {6'b0, m_pulse});
            check("cmp_sensors_valid", {7'b0, sig.sensors_valid}, {7'b0, m_valid});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic count_pulses(input int n, output int c0, output int c1, output int both,
                                output int maxrun0);
        int run0;
        c0 = 0; c1 = 0; both = 0; maxrun0 = 0; run0 = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
            if (sig.button_pulse[0]) begin
                c0++;
                run0++;
                if (run0 > maxrun0) maxrun0 = run0;
            end else begin
                run0 = 0;
            end
            if (sig.button_pulse[1]) c1++;
            if (sig.button_pulse == 2'b11) both++;
        end
    endtask

    initial begin
        int  c0, c1, both, mr, n;
        bit  found;

        sig.raw_sensors = 6'b000000;
        sig.raw_buttons = 2'b11;
        reset = 1'b1;
        repeat (3) @(posedge clock);

        // 1: hold 000011 from reset release
        sig.raw_sensors = 6'b000011;
        @(negedge clock);
        check("rst_stable", {2'b00, sig.stable_sensors}, 8'h00);
        check("rst_pulse", {6'b0, sig.button_pulse}, 8'h00);
        check("rst_valid", {7'b0, sig.sensors_valid}, 8'h00);
        reset = 1'b0;
        repeat (11) @(posedge clock);
        #1;
        check("t1_valid_c11", {7'b0, sig.sensors_valid}, 8'h00);
        check("t1_stable_c11", {2'b00, sig.stable_sensors}, 8'h00);
        @(posedge clock);
        #1;
        check("t1_valid_c12", {7'b0, sig.sensors_valid}, 8'h01);
        check("t1_stable_c12", {2'b00, sig.stable_sensors}, 8'h03);

        // 2: six-cycle glitch on high_water is rejected
        @(negedge clock);
        sig.raw_sensors[SNS_HIGH_WATER] = 1'b1;
        repeat (6) @(negedge clock);
        sig.raw_sensors[SNS_HIGH_WATER] = 1'b0;
        count_pulses(20, c0, c1, both, mr);
        check("t2_stable", {2'b00, sig.stable_sensors}, 8'h03);
        check("t2_no_pulse", 8'(c0 + c1), 8'h00);

        // 3: held step on high_water accepted within the latency window
        @(negedge clock);
        sig.raw_sensors[SNS_HIGH_WATER] = 1'b1;
        found = 1'b0;
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (!found && sig.stable_sensors[SNS_HIGH_WATER]) begin
                found = 1'b1;
                n = k;
            end
        end
        check("t3_seen", {7'b0, found}, 8'h01);
        check("t3_latency_in_10_15", {7'b0, (n >= 10 && n <= 15)}, 8'h01);
        check("t3_stable", {2'b00, sig.stable_sensors}, 8'h07);

        // 4: long press of pulse_3 -> one single-cycle pulse, none on release
        @(negedge clock);
        sig.raw_buttons[BTN_PULSE_3] = 1'b0;
        count_pulses(40, c0, c1, both, mr);
        check("t4_press_count", 8'(c0), 8'h01);
        check("t4_pulse_width", 8'(mr), 8'h01);
        check("t4_other_button", 8'(c1), 8'h00);
        @(negedge clock);
        sig.raw_buttons[BTN_PULSE_3] = 1'b1;
        count_pulses(30, c0, c1, both, mr);
        check("t4_release_count", 8'(c0 + c1), 8'h00);

        // 5: both buttons in the same cycle
        @(negedge clock);
        sig.raw_buttons = 2'b00;
        count_pulses(40, c0, c1, both, mr);
        check("t5_both_same_cycle", 8'(both), 8'h01);
        check("t5_count0", 8'(c0), 8'h01);
        check("t5_count1", 8'(c1), 8'h01);
        // held through reset: no pulse
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        count_pulses(40, c0, c1, both, mr);
        check("t5_held_reset", 8'(c0 + c1), 8'h00);
        @(negedge clock);
        sig.raw_buttons = 2'b11;
        count_pulses(30, c0, c1, both, mr);
        check("t5_release", 8'(c0 + c1), 8'h00);
        @(negedge clock);
        sig.raw_buttons = 2'b00;
        count_pulses(30, c0, c1, both, mr);
        check("t5_repress0", 8'(c0), 8'h01);
        check("t5_repress1", 8'(c1), 8'h01);

        // 6: async reset mid-debounce with all sensors stable high
        @(negedge clock);
        sig.raw_sensors = 6'b111111;
        repeat (30) @(posedge clock);
        #1;
        check("t6_all_high", {2'b00, sig.stable_sensors}, 8'h3F);
        @(negedge clock);
        sig.raw_sensors = 6'b000000;
        repeat (6) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("t6_async_stable", {2'b00, sig.stable_sensors}, 8'h00);
        check("t6_async_valid", {7'b0, sig.sensors_valid}, 8'h00);
        check("t6_async_pulse", {6'b0, sig.button_pulse}, 8'h00);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (11) @(posedge clock);
        #1;
        check("t6_valid_c11", {7'b0, sig.sensors_valid}, 8'h00);
        @(posedge clock);
        #1;
        check("t6_valid_c12", {7'b0, sig.sensors_valid}, 8'h01);

        repeat (4) @(posedge clock);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sensor_input_conditioner
`default_nettype wire
